// File: rtl/apb_master_arbiter.sv
// rtl/apb_master_arbiter.sv - two-requester round-robin APB master (optional PREADY timeout via APB_TIMEOUT_EN)
module apb_master_arbiter #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  input  logic [1:0]          req_write,
  input  logic [3:0]          req_sel,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          req_ack,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [1:0]          PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q;
  logic       id_q;
  logic       last_grant_q;
  logic       timeout_hit;
  logic       xfer_done;
  logic       arb_en;
  logic [1:0] cand;
  logic       win_any;
  logic       win_id;
  logic [1:0] win_sel;
  logic       win_legal;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;

  // Count consecutive wait-state cycles of the current ACCESS phase
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      to_cnt_q <= '0;
    end else if (state_q == S_ACCESS && !PREADY && !timeout_hit) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end else begin
      to_cnt_q <= '0;
    end
  end

  assign timeout_hit = (state_q == S_ACCESS) && !PREADY &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign xfer_done = (state_q == S_ACCESS) && (PREADY || timeout_hit);
  assign arb_en    = (state_q == S_IDLE) || xfer_done;

  // The requester finishing now is left out so it never gets ack and rsp in one cycle
  assign cand      = req_valid & ~((state_q == S_ACCESS) ? (2'b01 << id_q) : 2'b00);
  assign win_any   = |cand;
  assign win_id    = (&cand) ? ~last_grant_q : cand[1];
  assign win_sel   = win_id ? req_sel[3:2] : req_sel[1:0];
  assign win_legal = ^win_sel;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state: grant in IDLE or on completion; illegal selects skip the bus
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (win_any) state_d = win_legal ? S_SETUP : S_ERR;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (xfer_done) state_d = win_any ? (win_legal ? S_SETUP : S_ERR) : S_IDLE;
      S_ERR:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs: bus select/enable and the request acknowledge
  always_comb begin
    PSEL    = 2'b00;
    PENABLE = 1'b0;
    req_ack = 2'b00;
    case (state_q)
      S_SETUP: begin
        PSEL    = sel_q;
        req_ack = 2'b01 << id_q;
      end
      S_ACCESS: begin
        PSEL    = sel_q;
        PENABLE = 1'b1;
      end
      S_ERR:   req_ack = 2'b01 << id_q;
      default: ;
    endcase
  end

  // Capture the winner's fields into the bus registers on the grant edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sel_q        <= 2'b00;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
    end else if (arb_en && win_any) begin
      sel_q        <= win_sel;
      id_q         <= win_id;
      last_grant_q <= win_id;
      PWRITE       <= win_id ? req_write[1] : req_write[0];
      PADDR        <= win_id ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
      PWDATA       <= win_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
    end
  end

  // Response register: one-cycle pulse after completion, abort or illegal select
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      if (xfer_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_err   <= !PREADY || PSLVERR;
        rsp_rdata <= (PREADY && !PWRITE && !PSLVERR) ? PRDATA : '0;
      end else if (state_q == S_ERR) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb/tb_apb_master_arbiter.sv - directed self-checking bench for apb_master_arbiter
module tb_apb_master_arbiter;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic                PCLK = 1'b0;
  logic                PRESETn;
  logic [1:0]          req_valid;
  logic [1:0]          req_write;
  logic [3:0]          req_sel;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [1:0]          req_ack;
  logic                rsp_valid;
  logic                rsp_id;
  logic [DATA_W-1:0]   rsp_rdata;
  logic                rsp_err;
  logic [1:0]          PSEL;
  logic                PENABLE;
  logic                PWRITE;
  logic [ADDR_W-1:0]   PADDR;
  logic [DATA_W-1:0]   PWDATA;
  logic [DATA_W-1:0]   PRDATA;
  logic                PREADY;
  logic                PSLVERR;

  int n_checks = 0;
  int n_pass   = 0;

  apb_master_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge PCLK);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_psel"}, PSEL, 2'b00);
    check({tag, "_pen"}, PENABLE, 1'b0);
    check({tag, "_ack"}, req_ack, 2'b00);
    check({tag, "_rspv"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic bad_pen, bad_rsp;
    PRESETn = 1'b0; req_valid = 2'b00; req_write = 2'b00; req_sel = 4'b0000;
    req_addr = '0; req_wdata = '0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    step(); step();
    check_quiet("rst");
    check("rst_paddr", PADDR, 0);
    check("rst_rdata", rsp_rdata, 0);
    PRESETn = 1'b1;
    step(); step();
    check_quiet("idle");

    // req0 write, GPIO, addr 1, zero-wait slave
    req_valid = 2'b01; req_write = 2'b01; req_sel = 4'b0001;
    req_addr = {5'd0, 5'd1}; req_wdata = {32'h0, 32'hF0F0F0F0}; PREADY = 1'b1;
    step();
    check("w_setup_psel", PSEL, 2'b01);
    check("w_setup_pen", PENABLE, 1'b0);
    check("w_setup_ack", req_ack, 2'b01);
    req_valid = 2'b00;
    step();
    check("w_acc_pen", PENABLE, 1'b1);
    check("w_acc_psel", PSEL, 2'b01);
    check("w_acc_paddr", PADDR, 1);
    check("w_acc_pwdata", PWDATA, 32'hF0F0F0F0);
    check("w_acc_pwrite", PWRITE, 1'b1);
    check("w_acc_ack", req_ack, 2'b00);
    check("w_acc_rspv", rsp_valid, 1'b0);
    step();
    check("w_rsp_valid", rsp_valid, 1'b1);
    check("w_rsp_id", rsp_id, 1'b0);
    check("w_rsp_err", rsp_err, 1'b0);
    check("w_rsp_rdata", rsp_rdata, 0);
    check("w_rsp_psel", PSEL, 2'b00);
    check("w_rsp_pen", PENABLE, 1'b0);
    check("w_rsp_paddr_hold", PADDR, 1);
    step();
    check("w_rsp_pulse", rsp_valid, 1'b0);

    // req1 read, UART, addr 2, two wait states
    req_valid = 2'b10; req_write = 2'b00; req_sel = 4'b1000;
    req_addr = {5'd2, 5'd0}; PREADY = 1'b0; PRDATA = 32'h00000AAA;
    step();
    check("r_setup_psel", PSEL, 2'b10);
    check("r_setup_ack", req_ack, 2'b10);
    req_valid = 2'b00;
    step();
    check("r_acc1_pen", PENABLE, 1'b1);
    check("r_acc1_paddr", PADDR, 2);
    check("r_acc1_pwrite", PWRITE, 1'b0);
    step();
    check("r_acc2_pen", PENABLE, 1'b1);
    check("r_acc2_rspv", rsp_valid, 1'b0);
    step();
    check("r_acc3_pen", PENABLE, 1'b1);
    check("r_acc3_rspv", rsp_valid, 1'b0);
    PREADY = 1'b1;
    step();
    check("r_rsp_valid", rsp_valid, 1'b1);
    check("r_rsp_id", rsp_id, 1'b1);
    check("r_rsp_rdata", rsp_rdata, 32'h00000AAA);
    check("r_rsp_err", rsp_err, 1'b0);
    check("r_rsp_pen", PENABLE, 1'b0);
    step();

    // both requesters held: grants alternate 0,1,0,1 back-to-back
    req_valid = 2'b11; req_write = 2'b11; req_sel = 4'b1001;
    req_addr = {5'd4, 5'd3}; req_wdata = {32'h22222222, 32'h11111111};
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("rr%0d_ack", k), req_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr%0d_psel", k), PSEL, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr%0d_pen", k), PENABLE, 1'b0);
      if (k > 0) begin
        check($sformatf("rr%0d_rspv", k), rsp_valid, 1'b1);
        check($sformatf("rr%0d_rspid", k), rsp_id, (k % 2 == 0) ? 1'b1 : 1'b0);
      end
      step();
      check($sformatf("rr%0d_acc_pen", k), PENABLE, 1'b1);
      check($sformatf("rr%0d_acc_paddr", k), PADDR, (k % 2 == 0) ? 3 : 4);
      if (k == 3) req_valid = 2'b00;
    end
    step();
    check("rr_last_rspv", rsp_valid, 1'b1);
    check("rr_last_rspid", rsp_id, 1'b1);
    check("rr_last_psel", PSEL, 2'b00);
    step();

    // illegal select 11: ack then error response, no bus activity
    req_valid = 2'b01; req_sel = 4'b0011;
    step();
    check("ill_ack", req_ack, 2'b01);
    check("ill_psel", PSEL, 2'b00);
    check("ill_pen", PENABLE, 1'b0);
    req_valid = 2'b00;
    step();
    check("ill_rspv", rsp_valid, 1'b1);
    check("ill_err", rsp_err, 1'b1);
    check("ill_rdata", rsp_rdata, 0);
    check("ill_id", rsp_id, 1'b0);
    check("ill_psel2", PSEL, 2'b00);
    step();

    // slave error on a legal read
    req_valid = 2'b01; req_write = 2'b00; req_sel = 4'b0001;
    PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h12345678;
    step();
    req_valid = 2'b00;
    step();
    step();
    check("slverr_rspv", rsp_valid, 1'b1);
    check("slverr_err", rsp_err, 1'b1);
    check("slverr_rdata", rsp_rdata, 0);
    PSLVERR = 1'b0;
    step();

    // PREADY stuck low on a UART read
    req_valid = 2'b10; req_sel = 4'b1000; PREADY = 1'b0;
    step();
    req_valid = 2'b00;
    step();
`ifdef APB_TIMEOUT_EN
    cnt = 0;
    while (PENABLE && cnt < 200) begin
      cnt++;
      step();
    end
    check("to_access_cycles", cnt, 16);
    check("to_rspv", rsp_valid, 1'b1);
    check("to_err", rsp_err, 1'b1);
    check("to_rdata", rsp_rdata, 0);
    check("to_id", rsp_id, 1'b1);
    check("to_psel", PSEL, 2'b00);
    step();
    req_valid = 2'b01; req_sel = 4'b0001;
    step();
    req_valid = 2'b00;
    step();
`else
    bad_pen = 1'b0; bad_rsp = 1'b0;
    for (int i = 0; i < 110; i++) begin
      if (!PENABLE) bad_pen = 1'b1;
      if (rsp_valid) bad_rsp = 1'b1;
      step();
    end
    check("stuck_pen_held", bad_pen, 1'b0);
    check("stuck_no_rsp", bad_rsp, 1'b0);
`endif

    // asynchronous reset in the middle of ACCESS
    check("mid_pre_pen", PENABLE, 1'b1);
    PREADY = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    check_quiet("mid_rst");
    step();
    step();
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_quiet($sformatf("post_rst%0d", i));
    end

    // after reset requester 0 wins a simultaneous request
    req_valid = 2'b11; req_sel = 4'b1001;
    step();
    check("post_rst_first_grant", req_ack, 2'b01);
    req_valid = 2'b00;
    step();
    step();
    check("post_rst_rsp_id", rsp_id, 1'b0);
    check("post_rst_rspv", rsp_valid, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

APB master that shares the peripheral bus between two requesters (e.g. a host command port and a DMA/test port), arbitrating round-robin and sequencing each granted transfer through the APB SETUP and ACCESS phases. It drives the bus that selects the GPIO slave (PSEL=2'b01) and the UART slave (PSEL=2'b10). Each transfer completes with a single-cycle response carrying read data and error status.

## Interface
- ADDR_W, 5, PADDR / request address width
- DATA_W, 32, data width
- TIMEOUT_CYCLES, 16, PREADY wait limit; used only with APB_TIMEOUT_EN
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- req_valid  in  2  per-requester request; held with fields stable until matching req_ack bit
- req_write  in  2  1=write, 0=read, per requester
- req_sel  in  4  slave select, bits [2i+1:2i] for requester i; 01=GPIO, 10=UART
- req_addr  in  2*ADDR_W  address, slice i
- req_wdata  in  2*DATA_W  write data, slice i
- req_ack  out  2  one-cycle pulse: request i captured
- rsp_valid  out  1  one-cycle completion pulse
- rsp_id  out  1  requester that owns the response
- rsp_rdata  out  DATA_W  read data (0 for writes/errors)
- rsp_err  out  1  PSLVERR, illegal select, or timeout
- PSEL  out  2  slave select
- PENABLE  out  1  ACCESS phase
- PWRITE  out  1  direction
- PADDR  out  ADDR_W  address
- PWDATA  out  DATA_W  write data
- PRDATA  in  DATA_W  slave read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- FSM: IDLE, SETUP, ACCESS, ERR.
- Arbitration runs in IDLE and on the ACCESS completion edge. One valid requester wins; both valid -> winner is the one not granted last. last_grant resets to 1, so requester 0 wins first after reset.
- Grant edge: capture write/sel/addr/wdata of the winner into bus registers; store id.
- Captured sel 01/10 -> SETUP. Sel 00/11 -> ERR (no bus activity).
- SETUP: PSEL=captured sel, PENABLE=0, req_ack[id]=1. Always one cycle, then ACCESS.
- ACCESS: PENABLE=1, all bus outputs stable. PREADY=1 at an edge completes: latch PRDATA (reads only) and PSLVERR into rsp; rsp_valid pulses the following cycle.
- Completion with another valid request -> SETUP directly (back-to-back; PSEL may stay asserted, PENABLE drops one cycle). Otherwise -> IDLE; PSEL, PENABLE return to 0.
- ERR: req_ack[id]=1 for one cycle, then rsp_valid with rsp_err=1, rsp_rdata=0; -> IDLE.
- Requester must drop or change req_valid the cycle after its ack; a request still held is treated as new.
- PADDR/PWDATA/PWRITE hold their last values in IDLE.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS): state IDLE, all outputs 0, last_grant=1, timeout counter 0. Interrupted transfer produces no response.
- Latency, zero-wait slave: req_valid seen at edge N -> SETUP in cycle N+1 -> ACCESS N+2 -> rsp_valid N+3.
- Each PREADY=0 cycle in ACCESS adds one cycle.
- req_ack and rsp_valid never pulse for the same id in the same cycle; rsp_valid for transfer k coincides with SETUP of transfer k+1 when back-to-back.
- A requester's req_valid arriving on a completion edge is arbitrated on that edge.

## Configuration
- APB_TIMEOUT_EN defined: counter increments each ACCESS cycle with PREADY=0; on reaching TIMEOUT_CYCLES, abort: PSEL=0, PENABLE=0 next cycle, rsp_valid with rsp_err=1, rsp_rdata=0; -> IDLE (arbitration as on completion).
- Not defined: no counter; ACCESS waits for PREADY indefinitely.

## Test plan
- Reset asserted mid-stream -> all outputs 0 immediately; after release, bus idle until req_valid.
- req0 write, sel 01, addr 1, data F0F0F0F0, PREADY=1 -> PSEL=01/PENABLE=0 one cycle, PENABLE=1 one cycle, rsp_valid id0 err0 three cycles after request edge.
- req1 read, sel 10, addr 2, PREADY low 2 cycles, PRDATA=0x00000AAA -> ACCESS lasts 3 cycles, rsp_rdata=0x00000AAA, id1.
- Both requesters valid after reset, held across acks -> grants 0,1,0,1 alternate; back-to-back, PENABLE low exactly one cycle between transfers.
- req0 sel 11 -> no PSEL activity; req_ack[0] then rsp_valid with rsp_err=1, rsp_rdata=0. PSLVERR=1 on a legal access -> rsp_err=1.
- PREADY stuck 0, TIMEOUT_CYCLES=16, macro on -> abort after 16 ACCESS cycles, rsp_err=1; macro off -> PENABLE held high for 100+ cycles, no response.
